// File: rtl/conv_encoder_param.sv
// conv_encoder_param: rate-1/N, constraint-length-K convolutional encoder with
// valid/ready handshakes on both sides and optional zero-tail termination.
// One input bit is expanded into N code bits and serialised c_0 first; the
// input side is only opened on the cycle the last code bit of a symbol leaves,
// so streams run back-to-back at one input bit per N cycles.
module conv_encoder_param #(
   parameter int       K         = 3,
   parameter int       N         = 2,
   parameter logic [N*K-1:0] GEN = 6'b101_111,
   parameter bit       TERMINATE = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_bit,
   input  logic in_valid,
   input  logic in_last,
   output logic in_ready,
   output logic out_bit,
   output logic out_valid,
   output logic out_last,
   input  logic out_ready
);

   localparam int IW = $clog2(N);
   localparam int TW = $clog2(K);
   localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
   localparam logic [TW-1:0] TAIL_LAST = TW'(K - 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_TAIL
   } state_t;

   state_t          state_q, state_d;
   // Only the K-1 most recent bits are stored; the oldest tap of the K-bit
   // register is rebuilt from this history plus the incoming bit.
   logic [K-2:0]    sr_q, sr_d;
   logic [N-1:0]    cw_q, cw_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic            last_q, last_d;
   logic            out_bit_q, out_bit_d;
   logic            out_valid_q, out_valid_d;
   logic            out_last_q, out_last_d;

   logic            fire;
   logic            load_sym;
   logic            sym_bit;
   logic [K-1:0]    sr_new;

   // Parity of each generator against the K-bit register including the new bit.
   function automatic logic [N-1:0] encode(input logic [K-1:0] s);
      logic [N-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++) begin
         c[i] = ^(GEN[i*K +: K] & s);
      end
      return c;
   endfunction

   // Input handshake: open in IDLE, or exactly when the final code bit of a
   // non-last data symbol is being accepted downstream.
   always_comb begin
      in_ready = (state_q == S_IDLE) ||
                 ((state_q == S_DATA) && (idx_q == IDX_LAST) && out_ready && !last_q);
   end

   // Next-state, shift register, serialiser and registered-output computation.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      cw_d        = cw_q;
      idx_d       = idx_q;
      tcnt_d      = tcnt_q;
      last_d      = last_q;
      out_valid_d = out_valid_q;
      load_sym    = 1'b0;
      sym_bit     = 1'b0;
      sr_new      = '0;
      fire        = out_valid_q && out_ready;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               load_sym = 1'b1;
               sym_bit  = in_bit;
               last_d   = in_last;
               state_d  = S_DATA;
            end
         end
         S_DATA: begin
            if (fire) begin
               if (idx_q != IDX_LAST) begin
                  idx_d = idx_q + IW'(1);
               end else if (!last_q && in_valid) begin
                  // back-to-back: next symbol replaces the finished one
                  load_sym = 1'b1;
                  sym_bit  = in_bit;
                  last_d   = in_last;
               end else if (!last_q) begin
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
               end else if (TERMINATE) begin
                  load_sym = 1'b1;
                  sym_bit  = 1'b0;
                  tcnt_d   = '0;
                  last_d   = 1'b0;
                  state_d  = S_TAIL;
               end else begin
                  // unterminated frame: next frame starts from the zero state
                  sr_d        = '0;
                  last_d      = 1'b0;
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
               end
            end
         end
         S_TAIL: begin
            if (fire) begin
               if (idx_q != IDX_LAST) begin
                  idx_d = idx_q + IW'(1);
               end else if (tcnt_q == TAIL_LAST) begin
                  sr_d        = '0;
                  tcnt_d      = '0;
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
               end else begin
                  load_sym = 1'b1;
                  sym_bit  = 1'b0;
                  tcnt_d   = tcnt_q + TW'(1);
               end
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase

      if (load_sym) begin
         sr_new      = {sr_q, sym_bit};
         cw_d        = encode(sr_new);
         sr_d        = sr_new[K-2:0];
         idx_d       = '0;
         out_valid_d = 1'b1;
      end

      // The frame's final code bit: c_{N-1} of the last tail symbol, or of the
      // last data symbol when no tail is appended.
      out_last_d = out_valid_d && (idx_d == IDX_LAST) &&
                   (((state_d == S_DATA) && last_d && !TERMINATE) ||
                    ((state_d == S_TAIL) && (tcnt_d == TAIL_LAST)));
      out_bit_d  = out_valid_d ? cw_d[idx_d] : 1'b0;
   end

   // State and output registers; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sr_q        <= '0;
         cw_q        <= '0;
         idx_q       <= '0;
         tcnt_q      <= '0;
         last_q      <= 1'b0;
         out_bit_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cw_q        <= cw_d;
         idx_q       <= idx_d;
         tcnt_q      <= tcnt_d;
         last_q      <= last_d;
         out_bit_q   <= out_bit_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_bit   = out_bit_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

endmodule

// File: doc/conv_encoder_param.md
# conv_encoder_param

Parametrised, handshaked convolutional encoder. It generalises the fixed rate-1/2 serial encoder to constraint length K and rate 1/N with configurable generator polynomials. It adds optional zero-tail trellis termination and valid/ready flow control on both sides. It sits between the data source and the PRML channel model, feeding serial code bits to the channel and, downstream, the Viterbi decoder.

## Interface
- K, 3, constraint length (3..9); the shift register holds K bits.
- N, 2, code bits per input bit (2..4).
- GEN, 6'b101_111, packed generators, N*K bits; G_i = GEN[i*K +: K]. Default is the (7,5) code.
- TERMINATE, 1, 1 = append K-1 zero tail bits after in_last; 0 = no tail.
- Clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_bit  input  1  data bit.
- in_valid  input  1  in_bit/in_last valid.
- in_last  input  1  marks the final data bit of a frame.
- in_ready  output  1  encoder accepts a bit this cycle.
- out_bit  output  1  serial code bit.
- out_valid  output  1  out_bit valid.
- out_last  output  1  final code bit of the frame.
- out_ready  input  1  sink accepts out_bit this cycle.

## Operation
- Shift register sr[K-1:0]:
  - sr[0] is the newest bit; sr[j] is the bit j symbols earlier.
  - On each symbol: sr <= {sr[K-2:0], b}.
- Code bits per symbol: c_i = XOR over j of (G_i[j] & sr_new[j]), where sr_new includes the new bit.
- Serialisation order: c_0 first, then up to c_{N-1}.
- States:
  - IDLE: no symbol pending.
  - DATA: serialising a data symbol.
  - TAIL: serialising tail symbols, b=0.
- IDLE -> DATA on in_valid & in_ready. Computes the N-bit codeword into the serialiser, shifts sr, captures in_last.
- DATA, last serial bit accepted (out_valid & out_ready, index N-1):
  - If no captured last and in_valid: accept the next symbol the same cycle (back-to-back) and stay in DATA.
  - If no captured last and no in_valid: go to IDLE.
  - If captured last and TERMINATE=1: load tail symbol 1 and go to TAIL.
  - If captured last and TERMINATE=0: clear sr to 0 and go to IDLE.
- TAIL: K-1 tail symbols; tail counter runs 0..K-2. After the final tail bit is accepted: sr is all-zero and the state returns to IDLE.
- in_ready:
  - 1 in IDLE.
  - 1 in DATA only while the serial index is N-1, out_ready=1 and no last is captured.
  - 0 in TAIL.
  - Combinational from state, index and out_ready.
- out_last: asserted with the final code bit of the frame only. That is the last tail symbol's c_{N-1} (TERMINATE=1) or the last data symbol's c_{N-1} (TERMINATE=0).
- Backpressure: while out_valid & !out_ready, out_bit, out_last and all state hold unchanged.
- in_valid & !in_ready: ignored; no state change.

## Timing
- Reset (reset=0, asynchronous):
  - sr=0, state IDLE, serial index 0, tail counter 0.
  - out_valid=0, out_bit=0, out_last=0.
  - in_ready reads 1, but no transfer occurs while reset is asserted.
- Latency: a bit accepted at rising edge t drives out_valid=1 and out_bit=c_0 starting after edge t.
- Throughput: one input bit per N cycles with out_ready held at 1; no bubble between symbols.
- Frame overhead with TERMINATE=1: (K-1)*N extra code bits. The next frame's first bit is accepted no earlier than the cycle after out_last is transferred.
- Reset mid-frame: outputs clear asynchronously. After release the encoder is in IDLE with sr=0 and no partial codeword is emitted.
- All outputs are registered except in_ready.

## Test plan
- Frame encode, K=3, N=2, GEN default, TERMINATE=1, out_ready=1. Input 1,0,1,1 with last on the 4th bit -> out_bit 11 10 00 01 01 11 (12 bits, c_0 first), out_last only on bit 12, then sr=0.
- Same frame with TERMINATE=0 -> 11 10 00 01 (8 bits), out_last on bit 8. A following frame with single bit 1 (last) -> 11, proving sr was cleared.
- Backpressure: drop out_ready for 3 cycles mid-codeword in the first test -> out_bit/out_last are held, the sequence is unchanged, and in_ready stays 0 throughout the stall.
- Rate 1/3: K=3, N=3, GEN={011,101,111}, TERMINATE=0, single bit 1 with last -> 111, out_last on the 3rd bit.
- Reset mid-frame: assert reset during the 2nd codeword of the first test -> out_valid=0 immediately. After release, resend 1,0,1,1 -> the full 12-bit reference sequence with no residual bits.
- Back-to-back streaming: in_valid held high over 16 random bits with out_ready=1 -> in_ready pulses every N cycles, out_valid has no gaps, and the output matches a software (7,5) encoder model.
